// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in / serial-out serializer.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word skid (hold) register so a
// continuously valid upstream produces a gap-free serial stream.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output piso_state_e      dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the hold flag and reset, never on in_valid, and
  // the serial side has no backpressure: ser_out is valid whenever ser_valid.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;

  assign in_ready = rst & ~full_q;
  assign accept   = in_valid & in_ready;

  // The outgoing bit always sits at the end the register shifts away from.
  assign shifted  = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign head_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    hold_d  = hold_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sreg_d = shifted;
          cnt_d  = cnt_q + CW'(1);
          if (accept) begin
            hold_d = in_data;
            full_d = 1'b1;
          end
        end else if (full_q) begin
          sreg_d = hold_q;
          hold_d = '0;
          full_d = 1'b0;
          cnt_d  = '0;
        end else if (accept) begin
          // Word arriving exactly on the last bit bypasses the hold register.
          sreg_d = in_data;
          cnt_d  = '0;
        end else begin
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ser_valid = (state_q == SHIFT);
  assign ser_out   = ser_valid & head_bit;
  assign word_done = ser_valid & (cnt_q == LAST);
  assign dbg_state = state_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance,
// with a downstream right-shift register (new bit into MSB) on the LSB-first output.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         l_in_valid, l_in_ready, l_ser_out, l_ser_valid, l_word_done;
  logic [W-1:0] l_in_data;
  piso_state_e  l_state;
  logic         m_in_valid, m_in_ready, m_ser_out, m_ser_valid, m_word_done;
  logic [W-1:0] m_in_data;
  piso_state_e  m_state;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_data(l_in_data),
    .in_ready(l_in_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .word_done(l_word_done), .dbg_state(l_state)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_data(m_in_data),
    .in_ready(m_in_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .word_done(m_word_done), .dbg_state(m_state)
  );

  // downstream receiver model
  logic [W-1:0] rx_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_q <= '0;
    else if (l_ser_valid) rx_q <= {l_ser_out, rx_q[W-1:1]};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: advance one clock, land 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // serial-side check of one instance: {ser_valid, ser_out, word_done}
  task automatic chk_ser(input bit msb, input string tag, input logic v, input logic o, input logic d);
    if (msb) chk(tag, {29'd0, m_ser_valid, m_ser_out, m_word_done}, {29'd0, v, o, d});
    else     chk(tag, {29'd0, l_ser_valid, l_ser_out, l_word_done}, {29'd0, v, o, d});
  endtask

  initial begin
    l_in_valid = 1'b1; l_in_data = 4'hF;
    m_in_valid = 1'b1; m_in_data = 4'hF;

    // reset held with upstream valid
    rst = 1'b0;
    repeat (3) step();
    chk_ser(0, "rst_lsb_out", 1'b0, 1'b0, 1'b0);
    chk_ser(1, "rst_msb_out", 1'b0, 1'b0, 1'b0);
    chk("rst_ready", {30'd0, l_in_ready, m_in_ready}, 32'd0);
    l_in_valid = 1'b0; m_in_valid = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("rel_ready", {30'd0, l_in_ready, m_in_ready}, 32'd3);
    chk_ser(0, "rel_idle", 1'b0, 1'b0, 1'b0);

    // single word, LSB first
    l_in_valid = 1'b1; l_in_data = 4'b0011;
    step();
    l_in_valid = 1'b0;
    chk_ser(0, "sw_b0", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "sw_b1", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "sw_b2", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "sw_b3", 1'b1, 1'b0, 1'b1); step();
    chk_ser(0, "sw_end", 1'b0, 1'b0, 1'b0);
    chk("sw_rx", {28'd0, rx_q}, 32'h3);

    // back-to-back A then 5
    l_in_valid = 1'b1; l_in_data = 4'hA;
    step();
    l_in_data = 4'h5;
    chk_ser(0, "bb_b0", 1'b1, 1'b0, 1'b0);
    chk("bb_rdy0", {31'd0, l_in_ready}, 32'd1);
    step();
    l_in_valid = 1'b0;
    chk_ser(0, "bb_b1", 1'b1, 1'b1, 1'b0);
    chk("bb_rdy1", {31'd0, l_in_ready}, 32'd0); step();
    chk_ser(0, "bb_b2", 1'b1, 1'b0, 1'b0);
    chk("bb_rdy2", {31'd0, l_in_ready}, 32'd0); step();
    chk_ser(0, "bb_b3", 1'b1, 1'b1, 1'b1);
    chk("bb_rdy3", {31'd0, l_in_ready}, 32'd0); step();
    chk_ser(0, "bb_b4", 1'b1, 1'b1, 1'b0);
    chk("bb_rdy4", {31'd0, l_in_ready}, 32'd1); step();
    chk_ser(0, "bb_b5", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "bb_b6", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "bb_b7", 1'b1, 1'b0, 1'b1); step();
    chk_ser(0, "bb_end", 1'b0, 1'b0, 1'b0);
    chk("bb_rx", {28'd0, rx_q}, 32'h5);

    // MSB first
    m_in_valid = 1'b1; m_in_data = 4'b1000;
    step();
    m_in_valid = 1'b0;
    chk_ser(1, "msb_b0", 1'b1, 1'b1, 1'b0); step();
    chk_ser(1, "msb_b1", 1'b1, 1'b0, 1'b0); step();
    chk_ser(1, "msb_b2", 1'b1, 1'b0, 1'b0); step();
    chk_ser(1, "msb_b3", 1'b1, 1'b0, 1'b1); step();
    chk_ser(1, "msb_end", 1'b0, 1'b0, 1'b0);

    // reset mid-word with a held word
    l_in_valid = 1'b1; l_in_data = 4'hF;
    step();
    l_in_data = 4'h3;
    step();
    l_in_valid = 1'b0;
    chk("mr_full", {31'd0, l_in_ready}, 32'd0);
    chk_ser(0, "mr_b1", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_ser(0, "mr_rst", 1'b0, 1'b0, 1'b0);
    chk("mr_rst_rdy", {31'd0, l_in_ready}, 32'd0);
    step();
    #2 rst = 1'b1;
    l_in_valid = 1'b1; l_in_data = 4'h1;
    step();
    l_in_valid = 1'b0;
    chk_ser(0, "mr_b0", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "mr_b1b", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "mr_b2", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "mr_b3", 1'b1, 1'b0, 1'b1); step();
    chk_ser(0, "mr_end", 1'b0, 1'b0, 1'b0);
    chk("mr_rx", {28'd0, rx_q}, 32'h1);
    step();
    chk_ser(0, "mr_idle", 1'b0, 1'b0, 1'b0);

    // bypass on the word_done cycle
    l_in_valid = 1'b1; l_in_data = 4'h9;
    step();
    l_in_valid = 1'b0;
    chk_ser(0, "bp_b0", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "bp_b1", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "bp_b2", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "bp_b3", 1'b1, 1'b1, 1'b1);
    chk("bp_rdy", {31'd0, l_in_ready}, 32'd1);
    l_in_valid = 1'b1; l_in_data = 4'h6;
    step();
    l_in_valid = 1'b0;
    chk_ser(0, "bp_b4", 1'b1, 1'b0, 1'b0); step();
    chk_ser(0, "bp_b5", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "bp_b6", 1'b1, 1'b1, 1'b0); step();
    chk_ser(0, "bp_b7", 1'b1, 1'b0, 1'b1); step();
    chk_ser(0, "bp_end", 1'b0, 1'b0, 1'b0);
    chk("bp_state", {31'd0, l_state}, {31'd0, IDLE});
    chk("bp_rx", {28'd0, rx_q}, 32'h6);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_piso_serializer
